// File: rtl/nco_pkg.sv
// nco_pkg: shared constants and FSM state type for the NCO sample fetch path.
// Build option: NCO_FETCH_INTERP_EN adds the SMP2 state used for the second
// (interpolation) sample read.
package nco_pkg;

  localparam int unsigned WAVE_COUNT = 29;
  localparam int unsigned PAGE_W     = 8;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned FRAC_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OFF,
    ST_SMP,
`ifdef NCO_FETCH_INTERP_EN
    ST_SMP2,
`endif
    ST_CAP
  } state_e;

endpackage

// File: rtl/nco_interp.sv
// nco_interp: combinational linear interpolation between two signed samples.
//   s0, s1 : adjacent signed samples
//   frac   : unsigned position between them, in 1/16 steps
//   result : s0 + floor((s1 - s0) * frac / 16)
// Only instantiated when NCO_FETCH_INTERP_EN is defined.
module nco_interp
  import nco_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8
)(
  input  logic [SAMPLE_W-1:0] s0,
  input  logic [SAMPLE_W-1:0] s1,
  input  logic [FRAC_W-1:0]   frac,
  output logic [SAMPLE_W-1:0] result
);

  localparam int unsigned PW = SAMPLE_W + FRAC_W + 1;

  logic signed [SAMPLE_W:0] diff;
  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     step;

  // The interpolated value always lies between s0 and s1, so truncating
  // the step to SAMPLE_W bits before the add cannot overflow.
  always_comb begin
    diff   = $signed({s1[SAMPLE_W-1], s1}) - $signed({s0[SAMPLE_W-1], s0});
    prod   = PW'(diff) * PW'($signed({1'b0, frac}));
    step   = prod >>> FRAC_W;
    result = s0 + step[SAMPLE_W-1:0];
  end

endmodule

// File: rtl/nco_wave_fetch.sv
// nco_wave_fetch: NCO sample fetch stage. One request at a time: looks up the
// waveform page in the offset ROM, reads the sample ROM at {page, phase top
// byte}, and presents a registered sample with a one-cycle valid pulse.
// Build option: NCO_FETCH_INTERP_EN enables linear interpolation using a second
// read at the next index in the same page (latency 5 instead of 4).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start, wave, phase : request strobe and its operands (accepted when idle)
//   busy               : request in flight
//   sample, sample_valid : result and its one-cycle strobe
//   off_re/off_addr/off_data : offset ROM port (1-cycle read latency)
//   smp_re/smp_addr/smp_data : sample ROM port (1-cycle read latency)
module nco_wave_fetch
  import nco_pkg::*;
#(
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned WAVE_W   = 5
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WAVE_W-1:0]   wave,
  input  logic [PHASE_W-1:0]  phase,
  output logic                busy,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                off_re,
  output logic [WAVE_W-1:0]   off_addr,
  input  logic [7:0]          off_data,
  output logic                smp_re,
  output logic [15:0]         smp_addr,
  input  logic [SAMPLE_W-1:0] smp_data
);

  state_e              state_q, state_d;
  logic [WAVE_W-1:0]   off_addr_q, off_addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         smp_addr_q, smp_addr_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;
  logic [SAMPLE_W-1:0] result;

`ifdef NCO_FETCH_INTERP_EN
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [SAMPLE_W-1:0] s0_q, s0_d;

  nco_interp #(.SAMPLE_W(SAMPLE_W)) u_interp (
    .s0     (s0_q),
    .s1     (smp_data),
    .frac   (frac_q),
    .result (result)
  );
`else
  assign result = smp_data;
`endif

  // The offset ROM data only arrives in SMP, so smp_addr is driven
  // combinationally there and held in smp_addr_q afterwards.
  always_comb begin
    state_d        = state_q;
    off_addr_d     = off_addr_q;
    idx_d          = idx_q;
    smp_addr_d     = smp_addr_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
`ifdef NCO_FETCH_INTERP_EN
    frac_d         = frac_q;
    page_d         = page_q;
    s0_d           = s0_q;
`endif
    off_re         = 1'b0;
    smp_re         = 1'b0;
    smp_addr       = smp_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          off_addr_d = (32'(wave) >= WAVE_COUNT) ? '0 : wave;
          idx_d      = phase[PHASE_W-1 -: IDX_W];
`ifdef NCO_FETCH_INTERP_EN
          frac_d     = phase[PHASE_W-IDX_W-1 -: FRAC_W];
`endif
          state_d    = ST_OFF;
        end
      end
      ST_OFF: begin
        off_re  = 1'b1;
        state_d = ST_SMP;
      end
      ST_SMP: begin
        smp_re     = 1'b1;
        smp_addr   = {off_data, idx_q};
        smp_addr_d = smp_addr;
`ifdef NCO_FETCH_INTERP_EN
        page_d     = off_data;
        state_d    = ST_SMP2;
`else
        state_d    = ST_CAP;
`endif
      end
`ifdef NCO_FETCH_INTERP_EN
      ST_SMP2: begin
        // Index wraps inside the page; the page never carries.
        smp_re     = 1'b1;
        smp_addr   = {page_q, idx_q + IDX_W'(1)};
        smp_addr_d = smp_addr;
        s0_d       = smp_data;
        state_d    = ST_CAP;
      end
`endif
      ST_CAP: begin
        sample_d       = result;
        sample_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      off_addr_q     <= '0;
      idx_q          <= '0;
      smp_addr_q     <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
`ifdef NCO_FETCH_INTERP_EN
      frac_q         <= '0;
      page_q         <= '0;
      s0_q           <= '0;
`endif
    end else begin
      state_q        <= state_d;
      off_addr_q     <= off_addr_d;
      idx_q          <= idx_d;
      smp_addr_q     <= smp_addr_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
`ifdef NCO_FETCH_INTERP_EN
      frac_q         <= frac_d;
      page_q         <= page_d;
      s0_q           <= s0_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign off_addr     = off_addr_q;

endmodule

// File: tb/tb_nco_wave_fetch.sv
// tb_nco_wave_fetch: scoreboard bench for nco_wave_fetch with behavioural ROMs.
// Honours NCO_FETCH_INTERP_EN to select the interpolating reference model.
module tb_nco_wave_fetch;

`ifdef NCO_FETCH_INTERP_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  wave;
  logic [23:0] phase;
  logic        busy;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        off_re;
  logic [4:0]  off_addr;
  logic [7:0]  off_data;
  logic        smp_re;
  logic [15:0] smp_addr;
  logic [7:0]  smp_data;

  nco_wave_fetch #(.PHASE_W(24), .SAMPLE_W(8), .WAVE_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .wave         (wave),
    .phase        (phase),
    .busy         (busy),
    .sample       (sample),
    .sample_valid (sample_valid),
    .off_re       (off_re),
    .off_addr     (off_addr),
    .off_data     (off_data),
    .smp_re       (smp_re),
    .smp_addr     (smp_addr),
    .smp_data     (smp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ROMs with registered 1-cycle reads
  logic [7:0] off_rom [32];
  logic [7:0] smp_rom [65536];

  always @(posedge clk) begin
    if (off_re) off_data <= off_rom[off_addr];
    if (smp_re) smp_data <= smp_rom[smp_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  exp_t off_q[$];
  exp_t smp_q[$];
  exp_t out_q[$];

  int checks = 0;
  int errors = 0;
  int acc_cyc = -100;
  int next_ok = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int widx(input int w);
    return (w >= 29) ? 0 : w;
  endfunction

  // Reference: sample value from the ROM contents and the phase, by arithmetic
  function automatic logic [7:0] model(input int w, input logic [23:0] ph);
    int  base, i, s0;
    byte b;
`ifdef NCO_FETCH_INTERP_EN
    int  s1, f, p, q;
`endif
    base = int'(off_rom[widx(w)]) * 256;
    i    = int'(ph[23:16]);
    b    = smp_rom[base + i];
    s0   = b;
`ifdef NCO_FETCH_INTERP_EN
    b  = smp_rom[base + (i + 1) % 256];
    s1 = b;
    f  = int'(ph[15:12]);
    p  = (s1 - s0) * f;
    q  = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    s0 = s0 + q;
`endif
    return s0[7:0];
  endfunction

  // Drive one cycle of stimulus; if the request will be accepted, queue
  // every DUT event it should produce with the cycle it should appear in.
  task automatic drive(input bit st, input int w, input logic [23:0] ph,
                       input bit use_c, input logic [7:0] c);
    int          i;
    logic [7:0]  page;
    logic [7:0]  v;
    @(posedge clk);
    #1;
    start = st;
    wave  = w[4:0];
    phase = ph;
    if (st && cyc >= next_ok) begin
      page = off_rom[widx(w)];
      i    = int'(ph[23:16]);
      off_q.push_back('{cyc + 1, 16'(widx(w))});
      smp_q.push_back('{cyc + 2, {page, i[7:0]}});
`ifdef NCO_FETCH_INTERP_EN
      i = (i + 1) % 256;
      smp_q.push_back('{cyc + 3, {page, i[7:0]}});
`endif
      v = use_c ? c : model(w, ph);
      out_q.push_back('{cyc + LAT, {8'h00, v}});
      acc_cyc = cyc;
      next_ok = cyc + LAT;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 0, 24'h0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},         32'(busy),         32'h0);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'h0);
    chk({tag, "_sample"},       32'(sample),       32'h0);
    chk({tag, "_off_re"},       32'(off_re),       32'h0);
    chk({tag, "_smp_re"},       32'(smp_re),       32'h0);
    chk({tag, "_off_addr"},     32'(off_addr),     32'h0);
    chk({tag, "_smp_addr"},     32'(smp_addr),     32'h0);
  endtask

  // Monitor: pops expectations in the cycle they are due, flags any
  // ROM read or valid pulse that no accepted request accounts for.
  always @(negedge clk) begin
    exp_t e;
    if (off_q.size() > 0 && off_q[0].cyc == cyc) begin
      e = off_q.pop_front();
      chk("off_re", 32'(off_re), 32'h1);
      chk("off_addr", 32'(off_addr), 32'(e.val));
    end else if (off_re) begin
      chk("off_re_unexpected", 32'(off_re), 32'h0);
    end
    if (smp_q.size() > 0 && smp_q[0].cyc == cyc) begin
      e = smp_q.pop_front();
      chk("smp_re", 32'(smp_re), 32'h1);
      chk("smp_addr", 32'(smp_addr), 32'(e.val));
    end else if (smp_re) begin
      chk("smp_re_unexpected", 32'(smp_re), 32'h0);
    end
    if (out_q.size() > 0 && out_q[0].cyc == cyc) begin
      e = out_q.pop_front();
      chk("sample_valid", 32'(sample_valid), 32'h1);
      chk("sample", 32'(sample), 32'(e.val[7:0]));
    end else if (sample_valid) begin
      chk("sample_valid_unexpected", 32'(sample_valid), 32'h0);
    end
    chk("busy", 32'(busy), 32'((cyc > acc_cyc) && (cyc < acc_cyc + LAT)));
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    wave  = '0;
    phase = '0;

    for (int a = 0; a < 32; a++) off_rom[a] = 8'($urandom);
    for (int a = 0; a < 65536; a++) smp_rom[a] = 8'($urandom);
    off_rom[3] = 8'h05;
    off_rom[4] = 8'h07;
`ifdef NCO_FETCH_INTERP_EN
    smp_rom[16'h0540] = 8'h10;
    smp_rom[16'h0541] = 8'h30;
`else
    smp_rom[16'h0540] = 8'h20;
`endif
    smp_rom[16'h0710] = 8'h00;
    smp_rom[16'h0711] = 8'hF0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst     = 1'b0;
    next_ok = cyc;

    // Basic fetch, then a rejected start while busy, then a start at N+4
`ifdef NCO_FETCH_INTERP_EN
    drive(1'b1, 3, 24'h408000, 1'b1, 8'h20);
`else
    drive(1'b1, 3, 24'h400000, 1'b1, 8'h20);
`endif
    drive(1'b0, 0, 24'h0, 1'b0, 8'h00);
    drive(1'b1, 7, 24'($urandom), 1'b0, 8'h00);
    drive(1'b0, 0, 24'h0, 1'b0, 8'h00);
    drive(1'b1, 5, 24'($urandom), 1'b0, 8'h00);
    idle(6);

    // Out-of-range waveform falls back to index 0
    drive(1'b1, 30, 24'($urandom), 1'b0, 8'h00);
    idle(6);
    drive(1'b1, 31, 24'($urandom), 1'b0, 8'h00);
    idle(6);

    // Negative slope between 0x00 and 0xF0 with frac = 1
`ifdef NCO_FETCH_INTERP_EN
    drive(1'b1, 4, 24'h101000, 1'b1, 8'hFF);
`else
    drive(1'b1, 4, 24'h101000, 1'b1, 8'h00);
`endif
    idle(6);

    // Index 0xFF: interpolation partner wraps to the start of the page
    drive(1'b1, 3, {8'hFF, 16'($urandom)}, 1'b0, 8'h00);
    idle(6);

    // Randomised traffic, including back-to-back and rejected starts
    for (int k = 0; k < 400; k++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 24'($urandom), 1'b0, 8'h00);
    idle(8);

    // Mid-request reset: request dropped, outputs cleared next cycle
    drive(1'b1, 3, 24'($urandom), 1'b0, 8'h00);
    drive(1'b0, 0, 24'h0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    off_q.delete();
    smp_q.delete();
    out_q.delete();
    acc_cyc = -100;
    next_ok = cyc;
    chk_reset_vals("midreset");
    idle(8);

    // Recovery after reset
    drive(1'b1, int'($urandom_range(0, 31)), 24'($urandom), 1'b0, 8'h00);
    idle(2);

    for (int k = 0; k < 40 && (off_q.size() + smp_q.size() + out_q.size()) > 0; k++)
      @(posedge clk);
    chk("drain_pending", 32'(off_q.size() + smp_q.size() + out_q.size()), 32'h0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_wave_fetch.md
# nco_wave_fetch

Sample fetch stage of the NCO. It sits directly downstream of the wavetable offset ROM and drives that ROM's read port. Per request it looks up the selected waveform's page offset, forms the sample address from the phase accumulator's top bits, reads the wavetable sample ROM and presents one registered sample with a valid pulse. It serves one voice request at a time.

## Interface
- `PHASE_W`, 24: phase accumulator width.
- `SAMPLE_W`, 8: signed sample width.
- `WAVE_W`, 5: waveform index width.
- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request strobe; accepted only when `busy`=0.
- `wave`  in  WAVE_W: waveform select, latched on accept.
- `phase`  in  PHASE_W: phase, latched on accept.
- `busy`  out  1: request in flight.
- `sample`  out  SAMPLE_W: fetched sample (signed), held until next result.
- `sample_valid`  out  1: one-cycle pulse, `sample` updated.
- `off_re`  out  1: offset ROM read enable.
- `off_addr`  out  WAVE_W: offset ROM address.
- `off_data`  in  8: offset ROM data, valid 1 cycle after `off_re`.
- `smp_re`  out  1: sample ROM read enable.
- `smp_addr`  out  16: sample ROM address.
- `smp_data`  in  SAMPLE_W: sample ROM data, valid 1 cycle after `smp_re`.

## Operation
- States are IDLE, OFF, SMP, CAP. The interpolation build adds SMP2.
- IDLE: when `start`=1, latch `wave` and `phase`, then go to OFF. `start` is ignored in every other state; there is no queueing.
- Out-of-range waveform: if the latched `wave` ≥ WAVE_COUNT (29), index 0 is used instead.
- OFF: drive `off_re`=1 and `off_addr`=index, then go to SMP.
- SMP: drive `smp_re`=1 and `smp_addr`={`off_data`, idx}, where idx = `phase[PHASE_W-1 -: 8]`. Register `off_data`, then go to CAP.
- CAP: register `smp_data` into `sample`, assert `sample_valid` in the following cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `off_re` and `smp_re` are 0 outside their own states. `off_addr` and `smp_addr` hold their last value.
- Reset: returns to IDLE from any state, including mid-request; the request is dropped. Reset values: `busy`=0, `sample_valid`=0, `sample`=0, `off_re`=0, `smp_re`=0, `off_addr`=0, `smp_addr`=0.

## Timing
- `start` sampled in cycle N.
- `off_re` asserted in cycle N+1.
- `smp_re` asserted in cycle N+2.
- Data captured in cycle N+3.
- `sample_valid`=1 in cycle N+4.
- `busy`=1 in cycles N+1..N+3.
- A new `start` is accepted in cycle N+4, so the minimum request spacing is 4 cycles.
- Interpolation build: latency and spacing become 5 cycles.

## Configuration
- Macro: `NCO_FETCH_INTERP_EN`.
- Defined: linear interpolation between adjacent samples.
  - After SMP, state SMP2 reads `smp_addr`={offset, (idx+1) mod 256}. The index wraps within the page; the offset never carries.
  - frac = `phase[PHASE_W-9 -: 4]`.
  - `sample` = s0 + (((s1−s0) · frac) >>> 4).
  - Widths: difference is 9-bit signed, product 13-bit signed, arithmetic right shift (floor). The result is always within [min(s0,s1), max(s0,s1)], so it needs no saturation.
- Undefined: SMP2 and the interpolation arithmetic are absent; `sample` = s0.

## Structure
- Shared package `nco_pkg`:
  - WAVE_COUNT=29.
  - Page/index/frac widths (8/8/4).
  - State enum type.
- Sub-module `nco_interp`: combinational s0/s1/frac → result, instantiated only under `NCO_FETCH_INTERP_EN`.
- Both ROMs are external and are modelled in the bench with 1-cycle registered reads.

## Test plan
- Basic fetch: offset[3]=0x05, smp[0x0540]=0x20; `start`, `wave`=3, `phase`=0x400000 at N → `off_addr`=3 at N+1, `smp_addr`=0x0540 at N+2, `sample`=0x20 and `sample_valid`=1 at N+4 only.
- Busy rejection: a second `start` at N+2 (wave 7) → ignored, no extra ROM reads. A `start` at N+4 → accepted, second `sample_valid` at N+8.
- Out of range: `wave`=30 → `off_addr`=0.
- Mid-request reset: `rst` at N+2 → `busy`, `sample_valid`, `sample`, `off_re`, `smp_re`, `off_addr`, `smp_addr` all 0 at N+3; no valid pulse follows.
- Interpolation:
  - s[0x0540]=0x10, s[0x0541]=0x30, `phase`=0x408000 → `sample`=0x20 at N+5.
  - Wrap: idx=0xFF → second address 0x0500.
- Interpolation negative slope: s0=0x00, s1=0xF0, frac=1 → `sample`=0xFF.
